// File: rtl/lz77_decoder.sv
// LZ77 decoder: replays (offset, len, literal) triples from a shifting search buffer of
// recently emitted characters, then emits the literal; stops on the end-of-string literal.
module lz77_decoder #(
  parameter int unsigned     DICT_DEPTH = 9,
  parameter int unsigned     OFF_W      = 4,
  parameter int unsigned     LEN_W      = 3,
  parameter int unsigned     CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] END_CHAR = 8'h24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [CHAR_W-1:0] in_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              finish,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COPY = 2'd1;
  localparam logic [1:0] LIT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(DICT_DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  src_q, src_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [CHAR_W-1:0] lit_q, lit_d;
  logic              err_q, err_d;
  logic [CHAR_W-1:0] dict_q [DICT_DEPTH];
  logic [CHAR_W-1:0] dict_d [DICT_DEPTH];
  logic              shift;
  logic              lit_is_end;

  assign lit_is_end = (lit_q == END_CHAR);

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == COPY) || ((state_q == LIT) && !lit_is_end);
    finish    = (state_q == DONE);
    err       = err_q;
    out_char  = '0;
    if (state_q == COPY) begin
      out_char = dict_q[src_q];
    end else if ((state_q == LIT) && !lit_is_end) begin
      out_char = lit_q;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lit_d   = lit_q;
    err_d   = err_q;
    dict_d  = dict_q;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Out-of-range offsets are clamped to the oldest entry and flagged.
          src_d   = (in_offset > MAX_OFF) ? MAX_OFF : in_offset;
          len_d   = in_len;
          lit_d   = in_char;
          cnt_d   = '0;
          err_d   = err_q | (in_offset > MAX_OFF);
          state_d = (in_len != '0) ? COPY : LIT;
        end
      end
      COPY: begin
        if (out_ready) begin
          shift = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = LIT;
          end
        end
      end
      LIT: begin
        // The end literal is swallowed: never emitted, never stored.
        if (lit_is_end) begin
          state_d = DONE;
        end else if (out_ready) begin
          shift   = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (shift) begin
      dict_d[0] = out_char;
      for (int i = 1; i < DICT_DEPTH; i++) begin
        dict_d[i] = dict_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lit_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DICT_DEPTH; i++) begin
        dict_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      err_q   <= err_d;
      for (int i = 0; i < DICT_DEPTH; i++) begin
        dict_q[i] <= dict_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lz77_decoder.sv
// Bench for lz77_decoder: drives triples with random backpressure and compares the output
// stream against a queue-based history model of LZ77 decoding.
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_offset = '0;
  logic [2:0] in_len = '0;
  logic [7:0] in_char = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_char;
  logic       finish;
  logic       err;

  int errors = 0;
  int checks = 0;

  lz77_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_offset (in_offset),
    .in_len    (in_len),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .finish    (finish),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: hist[0] is the most recently emitted character.
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         exp_err;
  bit         tmo;
  int         first_lat;
  int         loop_cycles;
  int         stall_bad;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 9; i++) hist.push_back(8'h00);
    exp_err = 1'b0;
  endtask

  task automatic model_triple(input logic [3:0] off, input logic [2:0] len,
                              input logic [7:0] ch);
    int src;
    logic [7:0] c;
    exp_q = {};
    src = (off > 4'd8) ? 8 : int'(off);
    if (off > 4'd8) exp_err = 1'b1;
    for (int k = 0; k < int'(len); k++) begin
      c = hist[src];
      exp_q.push_back(c);
      hist.push_front(c);
      void'(hist.pop_back());
    end
    if (ch != 8'h24) begin
      exp_q.push_back(ch);
      hist.push_front(ch);
      void'(hist.pop_back());
    end
  endtask

  function automatic bit seq_same();
    if (got_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string seq_str(input bit use_got);
    string s = "";
    int n = use_got ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) s = {s, $sformatf(" %02h", use_got ? got_q[i] : exp_q[i])};
    return s;
  endfunction

  // Entered and left at 1 time unit after a rising edge. out_ready is random with the given
  // stall percentage, and forced low for n in [hold_start, hold_start+hold_len).
  task automatic run_triple(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch,
                            input int stall_pct, input int hold_start, input int hold_len);
    int n;
    bit prev_stall;
    logic [7:0] prev_char;
    got_q = {};
    tmo = 1'b0;
    first_lat = -1;
    stall_bad = 0;
    prev_stall = 1'b0;
    prev_char = '0;
    in_offset = off;
    in_len = len;
    in_char = ch;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tmo = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && !finish && n < 200) begin
      if (prev_stall && (!out_valid || out_char !== prev_char)) stall_bad++;
      if (out_valid) begin
        if (first_lat < 0) first_lat = n;
        if (n >= hold_start && n < hold_start + hold_len) out_ready = 1'b0;
        else out_ready = ($urandom_range(99) >= stall_pct);
        if (out_ready) got_q.push_back(out_char);
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      prev_stall = out_valid && !out_ready;
      prev_char = out_char;
      @(posedge clk); #1; n++;
    end
    if (n >= 200) tmo = 1'b1;
    loop_cycles = n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char got=%h exp=00", out_char); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_literal();
    model_triple(4'd0, 3'd0, 8'h01);
    run_triple(4'd0, 3'd0, 8'h01, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL literal_seq got=%s exp=%s tmo=%b", seq_str(1), seq_str(0), tmo); end
    checks++; if (first_lat !== 0) begin errors++; $display("FAIL literal_latency got=%0d exp=0", first_lat); end
    checks++; if (loop_cycles !== 1 || in_ready !== 1'b1) begin errors++; $display("FAIL literal_ready_return cycles=%0d in_ready=%b exp 1/1", loop_cycles, in_ready); end
  endtask

  task automatic test_overlap();
    model_triple(4'd0, 3'd3, 8'h02);
    run_triple(4'd0, 3'd3, 8'h02, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL overlap_seq got=%s exp=%s tmo=%b", seq_str(1), seq_str(0), tmo); end
    checks++; if (loop_cycles !== 4) begin errors++; $display("FAIL overlap_cycles got=%0d exp=4", loop_cycles); end
  endtask

  task automatic test_end();
    model_triple(4'd3, 3'd2, 8'h24);
    run_triple(4'd3, 3'd2, 8'h24, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL end_seq got=%s exp=%s tmo=%b", seq_str(1), seq_str(0), tmo); end
    checks++; if (finish !== 1'b1 || loop_cycles !== 3) begin errors++; $display("FAIL end_finish finish=%b cycles=%0d exp 1/3", finish, loop_cycles); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || finish !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_hold in_ready=%b finish=%b out_valid=%b exp 0/1/0", in_ready, finish, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    model_triple(4'd0, 3'd0, 8'h07); run_triple(4'd0, 3'd0, 8'h07, 0, 0, 0);
    model_triple(4'd0, 3'd0, 8'h08); run_triple(4'd0, 3'd0, 8'h08, 0, 0, 0);
    model_triple(4'd1, 3'd4, 8'h05);
    run_triple(4'd1, 3'd4, 8'h05, 0, 1, 3);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL bp_seq got=%s exp=%s tmo=%b", seq_str(1), seq_str(0), tmo); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold_stable got=%0d exp=0", stall_bad); end
    checks++; if (loop_cycles !== 8) begin errors++; $display("FAIL bp_cycles got=%0d exp=8", loop_cycles); end
  endtask

  task automatic test_illegal();
    logic [7:0] lits [9] = '{8'h0A, 8'h0A, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      model_triple(4'd0, 3'd0, lits[i]);
      run_triple(4'd0, 3'd0, lits[i], 20, 0, 0);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_before got=%b exp=0", err); end
    model_triple(4'd12, 3'd2, 8'h03);
    run_triple(4'd12, 3'd2, 8'h03, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL illegal_seq got=%s exp=%s tmo=%b", seq_str(1), seq_str(0), tmo); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", err); end
  endtask

  task automatic test_random();
    logic [3:0] off;
    logic [2:0] len;
    logic [7:0] ch;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      off = 4'($urandom_range(11));
      len = 3'($urandom_range(7));
      ch = 8'($urandom_range(255));
      if (ch == 8'h24) ch = 8'h25;
      model_triple(off, len, ch);
      run_triple(off, len, ch, 30, 0, 0);
      checks++;
      if (!seq_same() || tmo || stall_bad != 0 || err !== exp_err) begin
        errors++;
        $display("FAIL random_%0d (%0d,%0d,%02h) got=%s exp=%s err=%b/%b stall_bad=%0d tmo=%b",
                 t, off, len, ch, seq_str(1), seq_str(0), err, exp_err, stall_bad, tmo);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_offset = 4'd2; in_len = 3'd7; in_char = 8'h04; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_in_copy got=%b exp=1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_char !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state out_valid=%b in_ready=%b out_char=%h err=%b exp 0/1/00/0",
               out_valid, in_ready, out_char, err);
    end
    model_reset();
    model_triple(4'd0, 3'd0, 8'h01); run_triple(4'd0, 3'd0, 8'h01, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL midreset_lit got=%s exp=%s", seq_str(1), seq_str(0)); end
    model_triple(4'd0, 3'd3, 8'h02); run_triple(4'd0, 3'd3, 8'h02, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL midreset_overlap got=%s exp=%s", seq_str(1), seq_str(0)); end
    model_triple(4'd8, 3'd2, 8'h07); run_triple(4'd8, 3'd2, 8'h07, 0, 0, 0);
    checks++; if (!seq_same() || tmo) begin errors++; $display("FAIL midreset_oldest got=%s exp=%s", seq_str(1), seq_str(0)); end
  endtask

  initial begin
    test_reset();
    test_literal();
    test_overlap();
    test_end();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
- Reconstructs the character stream from the (offset, match_len, char_nxt) triples produced by the LZ77 encoder.
- Keeps a 9-entry search buffer of recently emitted characters and replays matches from it.
- Emits one decoded character per handshake, followed by the triple's literal.
- Sits downstream of the encoder, or of a code FIFO, and asserts finish when the end character 8'h24 ('$') arrives.

Parameters:
- DICT_DEPTH, 9, number of search-buffer entries; legal offsets are 0..DICT_DEPTH-1.
- OFF_W, 4, offset field width.
- LEN_W, 3, match_len field width; maximum match is 7.
- CHAR_W, 8, character width.
- END_CHAR, 8'h24, end-of-string literal.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  code triple present
- in_ready  output  1  decoder accepts a triple this cycle
- in_offset  input  OFF_W  distance into search buffer; 0 = most recently emitted char
- in_len  input  LEN_W  number of characters to copy
- in_char  input  CHAR_W  literal emitted after the copy
- out_valid  output  1  out_char valid
- out_ready  input  1  downstream accepts out_char
- out_char  output  CHAR_W  decoded character
- finish  output  1  END_CHAR literal received and all preceding output drained; sticky
- err  output  1  sticky; an illegal offset (>= DICT_DEPTH) was accepted

Behaviour:
- Clock and reset: clock clk; reset is synchronous and active-high. Reset clears everything in the same edge, including mid-COPY or mid-LIT.
- Reset values: state=IDLE, buf[0..DICT_DEPTH-1]=0, cnt=0, in_ready=1, out_valid=0, out_char=0, finish=0, err=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - COPY and LIT: in_ready=0, out_valid=1.
  - DONE: in_ready=0, out_valid=0, finish=1.
- IDLE: on in_valid&in_ready, latch off, len, lit and clear cnt. Next state is COPY if in_len!=0, else LIT.
- Source index: src=min(off, DICT_DEPTH-1). If off>=DICT_DEPTH, set err=1 at accept.
- COPY: out_char=buf[src] (combinational from registered state).
  - On out_valid&out_ready: shift buffer (buf[i]<=buf[i-1], buf[0]<=out_char) and cnt<=cnt+1.
  - When cnt==len-1 at the handshake, go to LIT.
  - Because the buffer shifts each emitted char, off stays constant. Overlapping copies (off<len) therefore repeat correctly with no special case.
- LIT when lit!=END_CHAR: out_char=lit. On handshake, shift lit into buf[0] and go to IDLE.
- LIT when lit==END_CHAR: out_valid=0, '$' is not emitted and not written to the buffer. Next cycle goes to DONE.
- DONE: holds until reset; in_valid is ignored.
- Backpressure: while out_valid&!out_ready, out_char, buffer, cnt and state are all held stable.
- Latency: a triple accepted at edge N gives first out_valid in the cycle after N. A triple with len L occupies L+1 output handshakes plus 1 IDLE cycle.
- Width: cnt is LEN_W bits; len=7 never overflows it.

Test Plan:
- Literal: after reset, triple (0,0,8'h01) -> exactly one output, 8'h01, one cycle after accept; buf[0]=01; in_ready returns high the cycle after the handshake.
- Overlapping copy: next triple (0,3,8'h02) -> outputs 01,01,01,02 on consecutive cycles with out_ready=1; buf[0..4]=02,01,01,01,01.
- End of stream: next triple (3,2,8'h24) -> outputs 01,01, then no '$'; finish=1 two cycles after the last handshake and stays high; a further in_valid is not accepted.
- Backpressure: during the COPY of (1,4,8'h05), hold out_ready=0 for 3 cycles -> out_char is unchanged, no extra chars appear, and the total sequence matches the unstalled run.
- Illegal offset: triple (12,2,8'h03) with buf[8]=8'h0A -> err=1 after accept; outputs 0A,0A,03.
- Reset mid-operation: assert reset during COPY of (2,7,8'h04) -> next cycle out_valid=0, in_ready=1, buffer all zero; the decode that follows is identical to the post-power-up run.
